// File: rtl/mem_logger_pkg.sv
// Shared constants and FSM state encoding for the sample-memory logger,
// reused by the controller, the packetiser and the bench.
package mem_logger_pkg;

  localparam int ML_DATA_W = 8;
  localparam int ML_ADDR_W = 4;
  localparam int ML_DEPTH  = 1 << ML_ADDR_W;
  localparam int ML_CNT_W  = ML_ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD      = 3'd2,
    RD_WAIT = 3'd3,
    OUT     = 3'd4
  } ml_state_t;

endpackage

// File: rtl/mem_logger_ctrl_ring_ptr_ctrl.sv
// Circular-buffer bookkeeping: write/read pointers and stored-word count.
// An overwrite push advances both pointers and keeps the count at full.
module ring_ptr_ctrl
  import mem_logger_pkg::*;
#(
  parameter int ADDR_WIDTH = ML_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  overwrite,
  output logic [ADDR_WIDTH-1:0] wr_ptr,
  output logic [ADDR_WIDTH-1:0] rd_ptr,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]   FULL_LVL = {1'b1, {ADDR_WIDTH{1'b0}}};

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      if (overwrite) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end else begin
        level <= level + CNT_ONE;
      end
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      level  <= level - CNT_ONE;
    end
  end

  assign full  = (level == FULL_LVL);
  assign empty = (level == '0);

endmodule

// File: rtl/mem_logger_ctrl.sv
// Sample-memory logger controller: circular write of samples, oldest-first drain on request.
// Optional feature macro: OVERWRITE_OLDEST_EN (overwrite oldest word when full and not draining).
module mem_logger_ctrl
  import mem_logger_pkg::*;
#(
  parameter int DATA_WIDTH = ML_DATA_W,
  parameter int ADDR_WIDTH = ML_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  smp_valid,
  input  logic [DATA_WIDTH-1:0] smp_data,
  output logic                  smp_ready,
  input  logic                  dump_req,
  output logic                  dump_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  ml_state_t             state, state_nx;
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  full, empty;
  logic                  push, pop, overwrite;
  logic                  smp_acc, issue_rd, last;

  ring_ptr_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .overwrite(overwrite),
    .wr_ptr   (wr_ptr),
    .rd_ptr   (rd_ptr),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

`ifdef OVERWRITE_OLDEST_EN
  // Full only backpressures while a drain is running; otherwise the oldest word is replaced.
  assign smp_ready = (state == IDLE) && (!full || !dump_busy);
  assign overwrite = full;
`else
  assign smp_ready = (state == IDLE) && !full;
  assign overwrite = 1'b0;
`endif

  assign smp_acc  = smp_valid && smp_ready;
  assign issue_rd = (state == IDLE) && !smp_acc && (dump_busy || (dump_req && !empty));
  assign last     = (level == CNT_ONE);
  assign out_last = out_valid && last;

  always_comb begin
    state_nx = state;
    push     = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        if (smp_acc) begin
          state_nx = WR;
        end else if (issue_rd) begin
          state_nx = RD;
        end
      end
      WR: begin
        push     = 1'b1;
        state_nx = IDLE;
      end
      RD:      state_nx = RD_WAIT;
      RD_WAIT: state_nx = OUT;
      OUT: begin
        if (out_ready) begin
          pop      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Memory strobes are single-cycle pulses launched from IDLE; read data lands during RD_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_data_in <= '0;
      mem_write   <= 1'b0;
      mem_read    <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      dump_busy   <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_write <= 1'b0;
      mem_read  <= 1'b0;
      if (smp_acc) begin
        mem_addr    <= wr_ptr;
        mem_data_in <= smp_data;
        mem_write   <= 1'b1;
      end else if (issue_rd) begin
        mem_addr <= rd_ptr;
        mem_read <= 1'b1;
      end
      if (state == RD_WAIT) begin
        out_data  <= mem_data_out;
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
      // Completion of the final word wins over a same-cycle request.
      if (pop && last) begin
        dump_busy <= 1'b0;
      end else if (dump_req && !empty) begin
        dump_busy <= 1'b1;
      end
    end
  end

`ifdef OVERWRITE_OLDEST_EN
  logic overflow_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
    end else if (push && overwrite) begin
      overflow_q <= 1'b1;
    end else if (pop && last) begin
      overflow_q <= 1'b0;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_mem_logger_ctrl.sv
// Bench for mem_logger_ctrl: directed scenarios plus random traffic against a queue model.
// Honours OVERWRITE_OLDEST_EN when the build defines it.
module tb_mem_logger_ctrl;
  import mem_logger_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       smp_valid;
  logic [7:0] smp_data;
  logic       smp_ready;
  logic       dump_req;
  logic       dump_busy;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic [4:0] level;
  logic       overflow;
  logic [3:0] mem_addr;
  logic [7:0] mem_data_in;
  logic       mem_write;
  logic       mem_read;
  logic [7:0] mem_data_out;

  mem_logger_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .smp_ready   (smp_ready),
    .dump_req    (dump_req),
    .dump_busy   (dump_busy),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .level       (level),
    .overflow    (overflow),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_write   (mem_write),
    .mem_read    (mem_read),
    .mem_data_out(mem_data_out)
  );

  // Single-port memory with registered read data.
  logic [7:0] mem [0:ML_DEPTH-1];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_data_in;
    if (mem_read) mem_data_out <= mem[mem_addr];
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of stored samples in arrival order.
  logic [7:0] q[$];
  int         pa[$];
  logic [7:0] pd[$];
  int         wr_cyc[$];
  int         wr_idx = 0;
  bit         exp_ovf = 0;
  int         n_out = 0;
  int         n_wr = 0;
  bit         prev_ov = 0, prev_rdy = 0;
  logic [7:0] prev_data = '0;

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      q.delete(); pa.delete(); pd.delete();
      wr_idx = 0; exp_ovf = 0; prev_ov = 0; prev_rdy = 0;
    end else begin
      chk("mem_excl", {31'b0, mem_write & mem_read}, 32'd0);
      if (!out_valid) chk("last_qual", {31'b0, out_last}, 32'd0);
      if (mem_write) begin
        n_wr++;
        wr_cyc.push_back(cyc);
        if (pa.size() == 0) chk("wr_spurious", 32'd1, 32'd0);
        else begin
          chk("wr_addr", {28'b0, mem_addr}, pa.pop_front());
          chk("wr_data", {24'b0, mem_data_in}, {24'b0, pd.pop_front()});
        end
      end
      if (mem_read)
        chk("rd_addr", {28'b0, mem_addr}, (wr_idx - q.size() + ML_DEPTH) % ML_DEPTH);
      if (out_valid && prev_ov && !prev_rdy)
        chk("out_stable", {24'b0, out_data}, {24'b0, prev_data});
      if (smp_valid && smp_ready) begin
        if (q.size() == ML_DEPTH) begin
`ifdef OVERWRITE_OLDEST_EN
          void'(q.pop_front());
          exp_ovf = 1;
`else
          chk("accept_full", 32'd1, 32'd0);
          void'(q.pop_front());
`endif
        end
        q.push_back(smp_data);
        pa.push_back(wr_idx);
        pd.push_back(smp_data);
        wr_idx = (wr_idx + 1) % ML_DEPTH;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("out_spurious", 32'd1, 32'd0);
        else begin
          bit el;
          el = (q.size() == 1);
          chk("out_data", {24'b0, out_data}, {24'b0, q.pop_front()});
          chk("out_last", {31'b0, out_last}, {31'b0, el});
          if (el) exp_ovf = 0;
        end
        n_out++;
      end
      prev_ov = out_valid; prev_rdy = out_ready; prev_data = out_data;
    end
  end

  // Consumer: 0 stall, 1 always ready, 2 random, 3 ready until n_out reaches budget.
  int rdy_mode = 0;
  int budget = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: out_ready = 1'b0;
        1: out_ready = 1'b1;
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (n_out < budget);
      endcase
    end
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_sample(input logic [7:0] d);
    int n = 0;
    smp_valid = 1'b1;
    smp_data  = d;
    @(negedge clk);
    while (!smp_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("smp_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    smp_valid = 1'b0;
  endtask

  task automatic pulse_dump();
    dump_req = 1'b1;
    @(posedge clk); #1;
    dump_req = 1'b0;
  endtask

  task automatic wait_drained();
    int n = 0;
    @(negedge clk);
    while (dump_busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    tick(3);
  endtask

  initial begin
    int base, n;
    rst_n = 1'b0; smp_valid = 1'b0; smp_data = '0; dump_req = 1'b0;
    tick(3);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_mem_write", {31'b0, mem_write}, 32'd0);
    chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
    chk("rst_busy", {31'b0, dump_busy}, 32'd0);
    chk("rst_level", {27'b0, level}, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    rst_n = 1'b1;
    tick(1);
    chk("rst_smp_ready", {31'b0, smp_ready}, 32'd1);

    // Three back-to-back samples.
    wr_cyc.delete();
    send_sample(8'h11); send_sample(8'h22); send_sample(8'h33);
    tick(3);
    chk("t1_level", {27'b0, level}, 32'd3);
    chk("t1_nwr", wr_cyc.size(), 32'd3);
    if (wr_cyc.size() == 3) begin
      chk("t1_gap01", wr_cyc[1] - wr_cyc[0], 32'd2);
      chk("t1_gap12", wr_cyc[2] - wr_cyc[1], 32'd2);
    end

    // Dump with a stalled consumer, checking request-to-data latency.
    rdy_mode = 0;
    base = n_out;
    pulse_dump();
    chk("t2_rd_lat", {31'b0, mem_read}, 32'd1);
    chk("t2_rd_addr", {28'b0, mem_addr}, 32'd0);
    chk("t2_busy", {31'b0, dump_busy}, 32'd1);
    tick(1);
    chk("t2_ov_early", {31'b0, out_valid}, 32'd0);
    tick(1);
    chk("t2_ov_lat", {31'b0, out_valid}, 32'd1);
    chk("t2_first", {24'b0, out_data}, 32'h11);
    tick(5);
    chk("t2_stall_data", {24'b0, out_data}, 32'h11);
    rdy_mode = 1;
    wait_drained();
    chk("t2_count", n_out - base, 32'd3);
    chk("t2_level", {27'b0, level}, 32'd0);
    chk("t2_busy_fall", {31'b0, dump_busy}, 32'd0);

`ifndef OVERWRITE_OLDEST_EN
    // Fill to full; the next sample must be held off.
    for (int i = 0; i < ML_DEPTH; i++) send_sample(8'(i * 2));
    tick(3);
    chk("t3_level", {27'b0, level}, 32'd16);
    chk("t3_ready", {31'b0, smp_ready}, 32'd0);
    chk("t3_overflow", {31'b0, overflow}, 32'd0);
    n = n_wr;
    smp_valid = 1'b1; smp_data = 8'h77;
    tick(6);
    chk("t3_held", n_wr - n, 32'd0);
    chk("t3_ready_held", {31'b0, smp_ready}, 32'd0);
    smp_valid = 1'b0;

    // Drain ten, append four across the wrap, then finish the drain.
    base = n_out;
    budget = base + 10;
    rdy_mode = 3;
    pulse_dump();
    n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (n_out < base + 10 && n < 2000);
    if (n >= 2000) chk("t4_timeout", 32'd1, 32'd0);
    for (int i = 0; i < 4; i++) send_sample(8'(8'hA0 + i));
    rdy_mode = 1;
    wait_drained();
    chk("t4_count", n_out - base, 32'd20);
    chk("t4_level", {27'b0, level}, 32'd0);
`endif

    // Reset while a word is presented.
    send_sample(8'h51); send_sample(8'h52); send_sample(8'h53);
    rdy_mode = 0;
    tick(2);
    pulse_dump();
    n = 0;
    while (!out_valid && n < 100) begin
      tick(1);
      n++;
    end
    chk("t5_out_valid", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    chk("t5_out_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_busy", {31'b0, dump_busy}, 32'd0);
    chk("t5_level", {27'b0, level}, 32'd0);
    chk("t5_mem_read", {31'b0, mem_read}, 32'd0);
    chk("t5_smp_ready", {31'b0, smp_ready}, 32'd1);
    rst_n = 1'b1;
    rdy_mode = 1;
    tick(2);

`ifdef OVERWRITE_OLDEST_EN
    // Full buffer overwritten by one sample, then drained.
    for (int i = 0; i < ML_DEPTH; i++) send_sample(8'(i * 2));
    tick(3);
    chk("t6_level_full", {27'b0, level}, 32'd16);
    chk("t6_ready_full", {31'b0, smp_ready}, 32'd1);
    send_sample(8'hAA);
    tick(3);
    chk("t6_overflow", {31'b0, overflow}, 32'd1);
    chk("t6_level", {27'b0, level}, 32'd16);
    base = n_out;
    pulse_dump();
    wait_drained();
    chk("t6_count", n_out - base, 32'd16);
    chk("t6_ovf_clear", {31'b0, overflow}, 32'd0);
`endif

    // Random traffic with a random consumer.
    rdy_mode = 2;
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5 && q.size() < ML_DEPTH) send_sample(8'($urandom));
      else if (r < 7) pulse_dump();
      else tick(1);
    end
    rdy_mode = 1;
    tick(4);
    chk("rnd_level_model", {27'b0, level}, q.size());
    chk("rnd_ovf_model", {31'b0, overflow}, {31'b0, exp_ovf});
    pulse_dump();
    wait_drained();
    chk("rnd_level_end", {27'b0, level}, 32'd0);
    chk("rnd_ovf_end", {31'b0, overflow}, {31'b0, exp_ovf});
    chk("rnd_pending", pa.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
